// File: rtl/glb_banked_dpram_pkg.sv
// Shared types and elaboration helpers for the banked GLB storage.
// Latency: none (package only).
// Backpressure: none (package only).
package glb_pkg;

  // Same-address read/write resolution policy.
  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  // Address bits consumed by bank selection (0 for a single bank).
  function automatic int glb_bank_bits(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Width of an index into n items, never narrower than one bit.
  function automatic int glb_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/glb_banked_dpram_if.sv
// Two-port storage access bundle: per-port write/read request and read return, plus collision flag.
// Latency: none (wires only).
// Backpressure: none; the storage accepts a request on every port every cycle.
interface glb_banked_dpram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR       = 10
);
  logic                  we_a;
  logic                  re_a;
  logic [ADDR-1:0]       addr_a;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic                  rvalid_a;

  logic                  we_b;
  logic                  re_b;
  logic [ADDR-1:0]       addr_b;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic                  rvalid_b;

  logic                  collision;

  modport master (
    output we_a, re_a, addr_a, wdata_a,
    output we_b, re_b, addr_b, wdata_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b, collision
  );

  modport slave (
    input  we_a, re_a, addr_a, wdata_a,
    input  we_b, re_b, addr_b, wdata_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b, collision
  );
endinterface

// File: rtl/glb_ram_bank.sv
// One true-dual-port block RAM bank; read-first on each port, registered read data.
// Latency: read data registered at the same edge the read is issued (1 cycle).
// Backpressure: none; caller guarantees the two ports never write the same word together.
module glb_ram_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int AW         = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we_a,
  input  logic                  i_re_a,
  input  logic [AW-1:0]         i_addr_a,
  input  logic [DATA_WIDTH-1:0] i_wdata_a,
  output logic [DATA_WIDTH-1:0] o_rdata_a,
  input  logic                  i_we_b,
  input  logic                  i_re_b,
  input  logic [AW-1:0]         i_addr_b,
  input  logic [DATA_WIDTH-1:0] i_wdata_b,
  output logic [DATA_WIDTH-1:0] o_rdata_b
);
  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata_a;
  logic [DATA_WIDTH-1:0] r_rdata_b;

  // Both ports in one process: reads see the pre-edge contents (read-first).
  always_ff @(posedge i_clk) begin
    if (i_re_a) r_rdata_a <= r_mem[i_addr_a];
    if (i_re_b) r_rdata_b <= r_mem[i_addr_b];
    if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
    if (i_we_b) r_mem[i_addr_b] <= i_wdata_b;
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;
endmodule

// File: rtl/glb_banked_dpram.sv
// Banked true-dual-port GLB storage, low-order interleaved, port A wins same-word write collisions.
// Latency: READ_LATENCY (1 or 2) edges from accepted read to rdata/rvalid; writes land at the issuing edge.
// Backpressure: none; both ports accept reads and writes every cycle, no stalls between banks.
module glb_banked_dpram
  import glb_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_BANKS    = 4,
  parameter int BANK_DEPTH   = 256,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input logic               core_clk,
  input logic               core_rst_n,
  glb_banked_dpram_if.slave bus
);
  localparam int ADDR   = $clog2(NUM_BANKS * BANK_DEPTH);
  localparam int BW     = glb_bank_bits(NUM_BANKS);
  localparam int BSEL_W = glb_idx_w(NUM_BANKS);
  localparam int LA     = glb_idx_w(BANK_DEPTH);
  localparam bit WRITE_FIRST = (rdw_mode_e'(RDW_MODE) == RDW_WRITE_FIRST);

  // Index 0 is port A, index 1 is port B.
  logic [1:0]            w_we;
  logic [1:0]            w_re;
  logic [1:0]            w_we_eff;
  logic [1:0]            w_inr;
  logic [1:0]            w_out_vld;
  logic [ADDR-1:0]       w_addr    [2];
  logic [DATA_WIDTH-1:0] w_wdata   [2];
  logic [DATA_WIDTH-1:0] w_out_dat [2];
  logic [LA-1:0]         w_la      [2];
  logic [BSEL_W-1:0]     w_bsel    [2];
  logic [DATA_WIDTH-1:0] w_bank_rd [2][NUM_BANKS];
  logic                  w_coll_now;
  logic                  r_coll;

  assign w_we       = {bus.we_b, bus.we_a};
  assign w_re       = {bus.re_b, bus.re_a};
  assign w_addr[0]  = bus.addr_a;
  assign w_addr[1]  = bus.addr_b;
  assign w_wdata[0] = bus.wdata_a;
  assign w_wdata[1] = bus.wdata_b;

  // Same-word double write: A's data is kept, B's write never reaches the bank.
  assign w_coll_now  = w_we[0] & w_we[1] & (w_addr[0] == w_addr[1]);
  assign w_we_eff[0] = w_we[0] & w_inr[0];
  assign w_we_eff[1] = w_we[1] & w_inr[1] & ~w_coll_now;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [ADDR-1:0]       w_hi;
    logic                  w_hit_a;
    logic                  w_hit_b;
    logic [DATA_WIDTH-1:0] w_rd_dat;
    logic                  r_vld1;
    logic                  r_oor1;
    logic                  r_byp1;
    logic [BSEL_W-1:0]     r_bsel1;
    logic [DATA_WIDTH-1:0] r_bypd1;
    logic                  r_vld2;
    logic [DATA_WIDTH-1:0] r_dat2;

    // Word index within a bank sits above the bank-select bits.
    assign w_hi     = w_addr[p] >> BW;
    assign w_inr[p] = ({1'b0, w_hi} < (ADDR+1)'(BANK_DEPTH));
    assign w_la[p]  = LA'(w_hi);

    if (BW > 0) begin : g_bsel
      assign w_bsel[p] = w_addr[p][BW-1:0];
    end else begin : g_nobsel
      assign w_bsel[p] = '0;
    end

    // A write to the word this port reads in the same cycle; A is checked first so it wins.
    assign w_hit_a = w_we_eff[0] & (w_addr[0] == w_addr[p]);
    assign w_hit_b = w_we_eff[1] & (w_addr[1] == w_addr[p]);

    // Stage 1: read accepted; remember which bank answers and whether the write data overrides it.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
        r_vld1  <= 1'b0;
        r_oor1  <= 1'b0;
        r_byp1  <= 1'b0;
        r_bsel1 <= '0;
        r_bypd1 <= '0;
      end else begin
        r_vld1 <= w_re[p];
        if (w_re[p]) begin
          r_oor1  <= ~w_inr[p];
          r_bsel1 <= w_bsel[p];
          r_byp1  <= WRITE_FIRST & (w_hit_a | w_hit_b);
          r_bypd1 <= w_hit_a ? w_wdata[0] : w_wdata[1];
        end
      end
    end

    // Output mux: out-of-range reads return zero, bypass beats the bank's old word.
    always_comb begin
      w_rd_dat = w_bank_rd[p][r_bsel1];
      if (r_byp1) w_rd_dat = r_bypd1;
      if (r_oor1) w_rd_dat = '0;
    end

    // Stage 2: first output register; data only moves on a valid read so it holds between reads.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
        r_vld2 <= 1'b0;
        r_dat2 <= '0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) r_dat2 <= w_rd_dat;
      end
    end

    if (READ_LATENCY == 2) begin : g_rl2
      logic                  r_vld3;
      logic [DATA_WIDTH-1:0] r_dat3;

      // Extra output register for timing-critical consumers.
      always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
          r_vld3 <= 1'b0;
          r_dat3 <= '0;
        end else begin
          r_vld3 <= r_vld2;
          if (r_vld2) r_dat3 <= r_dat2;
        end
      end

      assign w_out_vld[p] = r_vld3;
      assign w_out_dat[p] = r_dat3;
    end else begin : g_rl1
      assign w_out_vld[p] = r_vld2;
      assign w_out_dat[p] = r_dat2;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    glb_ram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BANK_DEPTH),
      .AW         (LA)
    ) u_bank (
      .i_clk     (core_clk),
      .i_we_a    (w_we_eff[0] & (w_bsel[0] == BSEL_W'(b))),
      .i_re_a    (w_re[0] & w_inr[0] & (w_bsel[0] == BSEL_W'(b))),
      .i_addr_a  (w_la[0]),
      .i_wdata_a (w_wdata[0]),
      .o_rdata_a (w_bank_rd[0][b]),
      .i_we_b    (w_we_eff[1] & (w_bsel[1] == BSEL_W'(b))),
      .i_re_b    (w_re[1] & w_inr[1] & (w_bsel[1] == BSEL_W'(b))),
      .i_addr_b  (w_la[1]),
      .i_wdata_b (w_wdata[1]),
      .o_rdata_b (w_bank_rd[1][b])
    );
  end

  // Collision flag is a one-cycle registered pulse after the offending edge.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) r_coll <= 1'b0;
    else             r_coll <= w_coll_now;
  end

  assign bus.rdata_a   = w_out_dat[0];
  assign bus.rvalid_a  = w_out_vld[0];
  assign bus.rdata_b   = w_out_dat[1];
  assign bus.rvalid_b  = w_out_vld[1];
  assign bus.collision = r_coll;
endmodule

// File: tb/tb_glb_banked_dpram.sv
// Directed bench: two instances share stimulus, one READ_LATENCY=1/READ_FIRST, one READ_LATENCY=2/WRITE_FIRST.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: none exercised; DUT never stalls.
module tb_glb_banked_dpram;
  logic core_clk;
  logic core_rst_n;
  int   n_vec;
  int   n_err;

  glb_banked_dpram_if #(.DATA_WIDTH(16), .ADDR(10)) if0 ();
  glb_banked_dpram_if #(.DATA_WIDTH(16), .ADDR(10)) if1 ();

  assign if1.we_a    = if0.we_a;
  assign if1.re_a    = if0.re_a;
  assign if1.addr_a  = if0.addr_a;
  assign if1.wdata_a = if0.wdata_a;
  assign if1.we_b    = if0.we_b;
  assign if1.re_b    = if0.re_b;
  assign if1.addr_b  = if0.addr_b;
  assign if1.wdata_b = if0.wdata_b;

  glb_banked_dpram #(
    .DATA_WIDTH(16), .NUM_BANKS(4), .BANK_DEPTH(256), .READ_LATENCY(1), .RDW_MODE(0)
  ) u_rl1 (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .bus        (if0)
  );

  glb_banked_dpram #(
    .DATA_WIDTH(16), .NUM_BANKS(4), .BANK_DEPTH(256), .READ_LATENCY(2), .RDW_MODE(1)
  ) u_rl2 (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .bus        (if1)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic idle();
    if0.we_a = 1'b0; if0.re_a = 1'b0; if0.addr_a = '0; if0.wdata_a = '0;
    if0.we_b = 1'b0; if0.re_b = 1'b0; if0.addr_b = '0; if0.wdata_b = '0;
  endtask

  task automatic wr_a(input logic [9:0] a, input logic [15:0] d);
    idle();
    if0.we_a = 1'b1; if0.addr_a = a; if0.wdata_a = d;
    tick();
    idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    core_rst_n = 1'b0;
    idle();
    repeat (2) tick();
    chk("rst_rvalid_a_rl1", 32'(if0.rvalid_a), 32'h0);
    chk("rst_rdata_a_rl1",  32'(if0.rdata_a),  32'h0);
    chk("rst_rvalid_b_rl2", 32'(if1.rvalid_b), 32'h0);
    chk("rst_coll_rl1",     32'(if0.collision), 32'h0);
    core_rst_n = 1'b1;
    tick();

    // Reset lands while a read is in flight: it must vanish.
    if0.re_a = 1'b1; if0.addr_a = 10'd0;
    tick();
    idle();
    core_rst_n = 1'b0;
    tick();
    chk("midrst_rvalid_rl1", 32'(if0.rvalid_a), 32'h0);
    chk("midrst_rdata_rl1",  32'(if0.rdata_a),  32'h0);
    chk("midrst_coll_rl1",   32'(if0.collision), 32'h0);
    tick();
    chk("midrst_rvalid_rl2", 32'(if1.rvalid_a), 32'h0);
    chk("midrst_rdata_rl2",  32'(if1.rdata_a),  32'h0);
    core_rst_n = 1'b1;
    tick();

    // Latency: write on A, read on B next cycle.
    wr_a(10'd5, 16'h1234);
    if0.re_b = 1'b1; if0.addr_b = 10'd5;
    tick();
    idle();
    chk("lat_e1_rvalid_rl1", 32'(if0.rvalid_b), 32'h0);
    chk("lat_e1_rvalid_rl2", 32'(if1.rvalid_b), 32'h0);
    tick();
    chk("lat_e2_rvalid_rl1", 32'(if0.rvalid_b), 32'h1);
    chk("lat_e2_rdata_rl1",  32'(if0.rdata_b),  32'h1234);
    chk("lat_e2_rvalid_rl2", 32'(if1.rvalid_b), 32'h0);
    tick();
    chk("lat_e3_rvalid_rl1", 32'(if0.rvalid_b), 32'h0);
    chk("lat_e3_hold_rl1",   32'(if0.rdata_b),  32'h1234);
    chk("lat_e3_rvalid_rl2", 32'(if1.rvalid_b), 32'h1);
    chk("lat_e3_rdata_rl2",  32'(if1.rdata_b),  32'h1234);
    tick();
    chk("lat_e4_rvalid_rl2", 32'(if1.rvalid_b), 32'h0);

    // Interleave: fill 0..7 through A, stream them back through B.
    for (int i = 0; i < 8; i++) wr_a(10'(i), 16'hA000 + 16'(i));
    begin
      int pulses1;
      int pulses2;
      pulses1 = 0;
      pulses2 = 0;
      for (int t = 0; t < 11; t++) begin
        idle();
        if (t < 8) begin
          if0.re_b = 1'b1; if0.addr_b = 10'(t);
        end
        tick();
        if (if0.rvalid_b) pulses1++;
        if (if1.rvalid_b) pulses2++;
        chk("ilv_rvalid_rl1", 32'(if0.rvalid_b), (t >= 1 && t <= 8) ? 32'h1 : 32'h0);
        if (t >= 1 && t <= 8) chk("ilv_rdata_rl1", 32'(if0.rdata_b), 32'hA000 + 32'(t - 1));
        chk("ilv_rvalid_rl2", 32'(if1.rvalid_b), (t >= 2 && t <= 9) ? 32'h1 : 32'h0);
        if (t >= 2 && t <= 9) chk("ilv_rdata_rl2", 32'(if1.rdata_b), 32'hA000 + 32'(t - 2));
      end
      idle();
      chk("ilv_pulses_rl1", 32'(pulses1), 32'd8);
      chk("ilv_pulses_rl2", 32'(pulses2), 32'd8);
    end

    // Collision: both ports write word 9, B also reads it that edge.
    wr_a(10'd9, 16'h0009);
    if0.we_a = 1'b1; if0.addr_a = 10'd9; if0.wdata_a = 16'h1111;
    if0.we_b = 1'b1; if0.addr_b = 10'd9; if0.wdata_b = 16'h2222;
    if0.re_b = 1'b1;
    tick();
    idle();
    chk("coll_pulse_rl1", 32'(if0.collision), 32'h1);
    chk("coll_pulse_rl2", 32'(if1.collision), 32'h1);
    tick();
    chk("coll_clear_rl1",  32'(if0.collision), 32'h0);
    chk("coll_rdfirst_rl1", 32'(if0.rdata_b),  32'h0009);
    tick();
    chk("coll_wrfirst_rl2", 32'(if1.rdata_b),  32'h1111);
    if0.re_a = 1'b1; if0.addr_a = 10'd9;
    tick();
    idle();
    tick();
    chk("coll_store_rl1", 32'(if0.rdata_a), 32'h1111);
    tick();
    chk("coll_store_rl2", 32'(if1.rdata_a), 32'h1111);

    // Cross-port read-during-write on word 3.
    wr_a(10'd3, 16'h00FF);
    if0.we_a = 1'b1; if0.addr_a = 10'd3; if0.wdata_a = 16'hBEEF;
    if0.re_b = 1'b1; if0.addr_b = 10'd3;
    tick();
    idle();
    tick();
    chk("rdw_x_rl1", 32'(if0.rdata_b), 32'h00FF);
    tick();
    chk("rdw_x_rl2", 32'(if1.rdata_b), 32'hBEEF);

    // Same-port read-during-write on word 3.
    if0.we_a = 1'b1; if0.re_a = 1'b1; if0.addr_a = 10'd3; if0.wdata_a = 16'h5555;
    tick();
    idle();
    tick();
    chk("rdw_s_rl1", 32'(if0.rdata_a), 32'hBEEF);
    tick();
    chk("rdw_s_rl2", 32'(if1.rdata_a), 32'h5555);

    // Same bank (0), different words: A reads 4, B writes 8.
    if0.re_a = 1'b1; if0.addr_a = 10'd4;
    if0.we_b = 1'b1; if0.addr_b = 10'd8; if0.wdata_b = 16'h8888;
    tick();
    idle();
    chk("bank_nocoll_rl1", 32'(if0.collision), 32'h0);
    tick();
    chk("bank_rd_rl1", 32'(if0.rdata_a), 32'hA004);
    tick();
    chk("bank_rd_rl2", 32'(if1.rdata_a), 32'hA004);
    if0.re_a = 1'b1; if0.addr_a = 10'd8;
    tick();
    idle();
    tick();
    chk("bank_wr_rl1", 32'(if0.rdata_a), 32'h8888);
    tick();
    chk("bank_wr_rl2", 32'(if1.rdata_a), 32'h8888);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
